error_sum_accumulator: RTL and testbench

- Downstream stage of the chromosome processing state machine. Consumes one evaluated circuit output byte per input sequence.
- Compares each byte bitwise against the expected output, under a per-bit valid mask.
- Accumulates per-output-bit mismatch counts over a run of N sequences.
- Exposes the 8 error sums to the HPS through a 4-phase done/feedback handshake.

---
 rtl/error_sum_accumulator_if.sv | 32 +++
 rtl/error_sum_accumulator.sv | 123 ++++++++++++
 tb/tb_error_sum_accumulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/error_sum_accumulator_if.sv
// Sample/handshake bus between the upstream evaluator, the error accumulator and the HPS.
// The slave modport is the accumulator side; the master modport is the driver/host side.
interface error_sum_accumulator_if #(
  parameter int unsigned NUM_OUTPUTS = 8,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned SEQ_WIDTH   = 8
);
  logic                               iStart;
  logic [SEQ_WIDTH-1:0]               iSequencesToProcess;
  logic                               iSampleValid;
  logic                               oSampleReady;
  logic [NUM_OUTPUTS-1:0]             iChromOutput;
  logic [NUM_OUTPUTS-1:0]             iExpectedOutput;
  logic [NUM_OUTPUTS-1:0]             iValidMask;
  logic                               iDoneFeedback;
  logic                               oDone;
  logic                               oBusy;
  logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] oErrorSums;
  logic [SEQ_WIDTH-1:0]               oSamplesSeen;

  modport master (
    output iStart, iSequencesToProcess, iSampleValid, iChromOutput, iExpectedOutput,
    output iValidMask, iDoneFeedback,
    input  oSampleReady, oDone, oBusy, oErrorSums, oSamplesSeen
  );

  modport slave (
    input  iStart, iSequencesToProcess, iSampleValid, iChromOutput, iExpectedOutput,
    input  iValidMask, iDoneFeedback,
    output oSampleReady, oDone, oBusy, oErrorSums, oSamplesSeen
  );
endinterface

// File: rtl/error_sum_accumulator.sv
// Per-output-bit mismatch counter over a run of sequences, with a two-stage compare/add
// pipeline and a 4-phase done/feedback handshake towards the HPS.
module error_sum_accumulator #(
  parameter int unsigned NUM_OUTPUTS = 8,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned SEQ_WIDTH   = 8
) (
  input logic                    iClock,
  input logic                    iReset,
  error_sum_accumulator_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StDone,
    StAck
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [SEQ_WIDTH-1:0]   r_remaining;
  logic [SEQ_WIDTH-1:0]   r_samples_seen;
  logic                   r_s1_valid;
  logic                   r_s2_valid;
  logic [NUM_OUTPUTS-1:0] r_s1_mismatch;
  logic [NUM_OUTPUTS-1:0] r_s2_mismatch;
  logic [COUNT_WIDTH-1:0] r_sums [NUM_OUTPUTS];

  logic w_start;
  logic w_ready;
  logic w_accept;

  assign w_start  = (r_state == StIdle) && bus.iStart;
  assign w_ready  = (r_state == StAccum) && (r_remaining != '0);
  assign w_accept = w_ready && bus.iSampleValid;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = (bus.iSequencesToProcess == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if ((r_remaining == '0) || (w_accept && (r_remaining == SEQ_WIDTH'(1)))) begin
          w_state_next = StDrain;
        end
      end
      // Results are only published once both pipeline stages have emptied into the sums.
      StDrain: begin
        if (!r_s1_valid && !r_s2_valid) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (bus.iDoneFeedback) begin
          w_state_next = StAck;
        end
      end
      StAck: begin
        if (!bus.iDoneFeedback) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state        <= StIdle;
      r_remaining    <= '0;
      r_samples_seen <= '0;
      r_s1_valid     <= 1'b0;
      r_s2_valid     <= 1'b0;
      r_s1_mismatch  <= '0;
      r_s2_mismatch  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_s1_valid    <= w_accept;
      r_s2_valid    <= r_s1_valid;
      r_s2_mismatch <= r_s1_mismatch;
      if (w_accept) begin
        r_s1_mismatch <= (bus.iChromOutput ^ bus.iExpectedOutput) & bus.iValidMask;
      end
      if (w_start) begin
        r_remaining    <= bus.iSequencesToProcess;
        r_samples_seen <= '0;
      end else if (w_accept) begin
        r_remaining    <= r_remaining - SEQ_WIDTH'(1);
        r_samples_seen <= r_samples_seen + SEQ_WIDTH'(1);
      end
    end
  end

  // Saturating counters; a start can only occur in IDLE, where stage 2 is already empty.
  always_ff @(posedge iClock) begin
    if (iReset || w_start) begin
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
        r_sums[k] <= '0;
      end
    end else if (r_s2_valid) begin
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
        if (r_s2_mismatch[k] && (r_sums[k] != '1)) begin
          r_sums[k] <= r_sums[k] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_sums
    assign bus.oErrorSums[k*COUNT_WIDTH +: COUNT_WIDTH] = r_sums[k];
  end

  assign bus.oSampleReady = w_ready;
  assign bus.oDone        = (r_state == StDone);
  assign bus.oBusy        = (r_state == StAccum) || (r_state == StDrain);
  assign bus.oSamplesSeen = r_samples_seen;

endmodule

// File: tb/tb_error_sum_accumulator.sv
// Directed bench for error_sum_accumulator: a 32-bit-counter instance for the main runs and a
// 4-bit-counter instance for saturation.
module tb_error_sum_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  error_sum_accumulator_if #(.NUM_OUTPUTS(8), .COUNT_WIDTH(32), .SEQ_WIDTH(8)) bus_a ();
  error_sum_accumulator_if #(.NUM_OUTPUTS(8), .COUNT_WIDTH(4), .SEQ_WIDTH(8)) bus_b ();

  error_sum_accumulator #(.NUM_OUTPUTS(8), .COUNT_WIDTH(32), .SEQ_WIDTH(8)) u_dut_a (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus_a.slave)
  );

  error_sum_accumulator #(.NUM_OUTPUTS(8), .COUNT_WIDTH(4), .SEQ_WIDTH(8)) u_dut_b (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sum_a(input int k);
    return bus_a.oErrorSums[k*32 +: 32];
  endfunction

  task automatic start_a(input logic [7:0] n);
    bus_a.iStart              = 1'b1;
    bus_a.iSequencesToProcess = n;
    tick();
    bus_a.iStart              = 1'b0;
  endtask

  task automatic drive_sample(input logic [7:0] c, input logic [7:0] e, input logic [7:0] m);
    bus_a.iSampleValid    = 1'b1;
    bus_a.iChromOutput    = c;
    bus_a.iExpectedOutput = e;
    bus_a.iValidMask      = m;
    tick();
    bus_a.iSampleValid    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!bus_a.oDone && cycles < budget) begin
      tick();
      cycles++;
    end
    check_eq(tag, 64'(bus_a.oDone), 64'd1);
  endtask

  task automatic check_all_sums(input string tag, input logic [31:0] lo, input logic [31:0] hi);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("%s_sum%0d", tag, k), 64'(sum_a(k)), 64'(k < 4 ? lo : hi));
    end
  endtask

  initial begin
    int cycles;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus_a.iStart = 1'b0; bus_a.iSequencesToProcess = '0; bus_a.iSampleValid = 1'b0;
    bus_a.iChromOutput = '0; bus_a.iExpectedOutput = '0; bus_a.iValidMask = '0;
    bus_a.iDoneFeedback = 1'b0;
    bus_b.iStart = 1'b0; bus_b.iSequencesToProcess = '0; bus_b.iSampleValid = 1'b0;
    bus_b.iChromOutput = '0; bus_b.iExpectedOutput = '0; bus_b.iValidMask = '0;
    bus_b.iDoneFeedback = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_done", 64'(bus_a.oDone), 64'd0);
    check_eq("rst_busy", 64'(bus_a.oBusy), 64'd0);
    check_eq("rst_ready", 64'(bus_a.oSampleReady), 64'd0);
    check_eq("rst_seen", 64'(bus_a.oSamplesSeen), 64'd0);
    check_all_sums("rst", 32'd0, 32'd0);

    // Strobes in IDLE are ignored
    drive_sample(8'hFF, 8'h00, 8'hFF);
    drive_sample(8'hFF, 8'h00, 8'hFF);
    repeat (3) tick();
    check_eq("idle_seen", 64'(bus_a.oSamplesSeen), 64'd0);
    check_eq("idle_sum0", 64'(sum_a(0)), 64'd0);

    // Run 1: three back-to-back samples, every bit mismatches exactly once
    start_a(8'd3);
    check_eq("t1_busy", 64'(bus_a.oBusy), 64'd1);
    check_eq("t1_ready", 64'(bus_a.oSampleReady), 64'd1);
    drive_sample(8'hFF, 8'h00, 8'hFF);
    drive_sample(8'h0F, 8'h0F, 8'hFF);
    drive_sample(8'h01, 8'h00, 8'h00);
    check_eq("t1_ready_drop", 64'(bus_a.oSampleReady), 64'd0);
    check_eq("t1_done_early", 64'(bus_a.oDone), 64'd0);
    wait_done("t1_done_timeout", 20, cycles);
    check_eq("t1_done_lat_ge2", 64'(cycles >= 2), 64'd1);
    check_all_sums("t1", 32'd1, 32'd1);
    check_eq("t1_seen", 64'(bus_a.oSamplesSeen), 64'd3);
    check_eq("t1_busy_done", 64'(bus_a.oBusy), 64'd0);
    bus_a.iDoneFeedback = 1'b1;
    tick();
    check_eq("t1_ack_done", 64'(bus_a.oDone), 64'd0);
    bus_a.iDoneFeedback = 1'b0;
    tick();
    check_eq("t1_idle_busy", 64'(bus_a.oBusy), 64'd0);
    check_all_sums("t1_hold", 32'd1, 32'd1);

    // Run 2: restart clears sums; sparse samples; iStart ignored in ACCUM and DONE
    start_a(8'd2);
    check_eq("t2_clr_sum0", 64'(sum_a(0)), 64'd0);
    check_eq("t2_clr_sum7", 64'(sum_a(7)), 64'd0);
    check_eq("t2_clr_seen", 64'(bus_a.oSamplesSeen), 64'd0);
    drive_sample(8'hAA, 8'h55, 8'h0F);
    check_eq("t2_seen1", 64'(bus_a.oSamplesSeen), 64'd1);
    tick();
    start_a(8'd7);
    tick();
    check_eq("t2_start_ign_ready", 64'(bus_a.oSampleReady), 64'd1);
    check_eq("t2_start_ign_seen", 64'(bus_a.oSamplesSeen), 64'd1);
    drive_sample(8'hAA, 8'h55, 8'h0F);
    check_eq("t2_ready_drop", 64'(bus_a.oSampleReady), 64'd0);
    check_eq("t2_busy", 64'(bus_a.oBusy), 64'd1);
    drive_sample(8'hAA, 8'h55, 8'h0F);
    wait_done("t2_done_timeout", 20, cycles);
    check_all_sums("t2", 32'd2, 32'd0);
    check_eq("t2_seen", 64'(bus_a.oSamplesSeen), 64'd2);
    start_a(8'd5);
    check_eq("t2_done_start_ign", 64'(bus_a.oDone), 64'd1);
    check_eq("t2_done_start_sum0", 64'(sum_a(0)), 64'd2);
    check_eq("t2_done_start_seen", 64'(bus_a.oSamplesSeen), 64'd2);
    bus_a.iDoneFeedback = 1'b1;
    tick();
    bus_a.iDoneFeedback = 1'b0;
    tick();

    // Run 3: N=0 goes straight to DONE
    start_a(8'd0);
    check_eq("t3_done", 64'(bus_a.oDone), 64'd1);
    check_eq("t3_busy", 64'(bus_a.oBusy), 64'd0);
    check_eq("t3_sum0", 64'(sum_a(0)), 64'd0);
    check_eq("t3_seen", 64'(bus_a.oSamplesSeen), 64'd0);
    bus_a.iDoneFeedback = 1'b1;
    tick();
    check_eq("t3_ack_done", 64'(bus_a.oDone), 64'd0);
    tick();
    check_eq("t3_ack_hold", 64'(bus_a.oDone), 64'd0);
    bus_a.iDoneFeedback = 1'b0;
    tick();
    check_eq("t3_idle_done", 64'(bus_a.oDone), 64'd0);

    // Feedback already high on entering DONE: oDone for exactly one cycle
    bus_a.iDoneFeedback = 1'b1;
    start_a(8'd0);
    check_eq("t3b_done", 64'(bus_a.oDone), 64'd1);
    tick();
    check_eq("t3b_done_one_cycle", 64'(bus_a.oDone), 64'd0);
    bus_a.iDoneFeedback = 1'b0;
    tick();

    // Reset mid-ACCUM after 5 of 10 samples
    start_a(8'd10);
    repeat (5) drive_sample(8'hFF, 8'h00, 8'hFF);
    repeat (3) tick();
    check_eq("t6_pre_sum3", 64'(sum_a(3)), 64'd5);
    check_eq("t6_pre_seen", 64'(bus_a.oSamplesSeen), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_sums("t6", 32'd0, 32'd0);
    check_eq("t6_seen", 64'(bus_a.oSamplesSeen), 64'd0);
    check_eq("t6_busy", 64'(bus_a.oBusy), 64'd0);
    check_eq("t6_ready", 64'(bus_a.oSampleReady), 64'd0);
    check_eq("t6_done", 64'(bus_a.oDone), 64'd0);
    drive_sample(8'hFF, 8'h00, 8'hFF);
    repeat (2) tick();
    check_eq("t6_idle_seen", 64'(bus_a.oSamplesSeen), 64'd0);

    // Start coincident with reset: reset wins
    rst                       = 1'b1;
    bus_a.iStart              = 1'b1;
    bus_a.iSequencesToProcess = 8'd3;
    tick();
    rst          = 1'b0;
    bus_a.iStart = 1'b0;
    check_eq("t8_busy", 64'(bus_a.oBusy), 64'd0);
    check_eq("t8_ready", 64'(bus_a.oSampleReady), 64'd0);

    // Saturation on the 4-bit counter build: 20 mismatches on bit 0 clamp at 15
    bus_b.iStart              = 1'b1;
    bus_b.iSequencesToProcess = 8'd20;
    tick();
    bus_b.iStart          = 1'b0;
    bus_b.iSampleValid    = 1'b1;
    bus_b.iChromOutput    = 8'h01;
    bus_b.iExpectedOutput = 8'h00;
    bus_b.iValidMask      = 8'hFF;
    repeat (20) tick();
    bus_b.iSampleValid = 1'b0;
    cycles = 0;
    while (!bus_b.oDone && cycles < 50) begin
      tick();
      cycles++;
    end
    check_eq("sat_done_timeout", 64'(bus_b.oDone), 64'd1);
    check_eq("sat_sum0", 64'(bus_b.oErrorSums[3:0]), 64'd15);
    check_eq("sat_sum1", 64'(bus_b.oErrorSums[7:4]), 64'd0);
    check_eq("sat_seen", 64'(bus_b.oSamplesSeen), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
